fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_pkg.sv | 16 +
 rtl/uart_baud_cnt.sv | 29 ++
 rtl/fifo_uart_tx.sv | 120 ++++++++++++
 tb/tb_fifo_uart_tx.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

  localparam int DATA_W           = 8;
  localparam int CLKS_PER_BIT_DEF = 868;  // 100 MHz / 115200 baud

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    STOP
  } state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Free-running within a bit; wraps on its own terminal count so bits chain seamlessly.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter that pulls bytes from an upstream synchronous FIFO.
//
//   state | meaning
//   IDLE  | line high, waiting for en and a non-empty FIFO
//   FETCH | one-cycle read strobe to the FIFO
//   LOAD  | FIFO data now valid; capture it and restart the bit timer
//   START | start bit (tx=0)
//   DATA  | eight data bits, LSB first
//   STOP  | stop bit (tx=1); byte_done on its last cycle
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              byte_done
);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   sreg_q, sreg_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic                tx_q, tx_d;
  logic                baud_clr;
  logic                baud_tick;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .reset(reset),
    .clr  (baud_clr),
    .tick (baud_tick)
  );

  // State, shift register, bit index and the registered serial output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
    end
  end

  // Next-state logic; tx_d is set on the transition so tx changes on the entry edge.
  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    bit_idx_d  = bit_idx_q;
    tx_d       = tx_q;
    fifo_rd_en = 1'b0;
    byte_done  = 1'b0;
    baud_clr   = 1'b1;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (en && !fifo_empty) state_d = FETCH;
      end
      FETCH: begin
        fifo_rd_en = 1'b1;
        state_d    = LOAD;
      end
      LOAD: begin
        sreg_d    = fifo_dout;
        bit_idx_d = '0;
        tx_d      = 1'b0;
        state_d   = START;
      end
      START: begin
        baud_clr = 1'b0;
        if (baud_tick) begin
          state_d   = DATA;
          bit_idx_d = '0;
          tx_d      = sreg_q[0];
        end
      end
      DATA: begin
        baud_clr = 1'b0;
        if (baud_tick) begin
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            sreg_d    = {1'b0, sreg_q[DATA_W-1:1]};
            tx_d      = sreg_q[1];
          end
        end
      end
      STOP: begin
        baud_clr = 1'b0;
        tx_d     = 1'b1;
        if (baud_tick) begin
          byte_done = 1'b1;
          state_d   = (en && !fifo_empty) ? FETCH : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign tx   = tx_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx driven from a small synchronous FIFO; line decoded against ideal frames.
module tb_fifo_uart_tx;

  localparam int C  = 4;
  localparam int FW = 10 * C;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       fifo_rd_en;
  logic       tx;
  logic       busy;
  logic       byte_done;

  logic       fifo_rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] fmem [32];
  int         wp, rp, fcnt;

  int errors = 0;
  int checks = 0;
  int rd_cnt = 0;
  int rd_viol = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .fifo_empty(fifo_empty),
    .fifo_dout (fifo_dout),
    .fifo_rd_en(fifo_rd_en),
    .tx        (tx),
    .busy      (busy),
    .byte_done (byte_done)
  );

  // Upstream synchronous FIFO: read data appears the cycle after rd_en is sampled.
  always @(posedge clk) begin
    if (fifo_rst) begin
      wp <= 0; rp <= 0; fcnt <= 0; fifo_dout <= 8'h00;
    end else begin
      if (wr_en) begin
        fmem[wp] <= wr_data;
        wp <= (wp + 1) % 32;
      end
      if (fifo_rd_en && fcnt != 0) begin
        fifo_dout <= fmem[rp];
        rp <= (rp + 1) % 32;
      end
      fcnt <= fcnt + (wr_en ? 1 : 0) - ((fifo_rd_en && fcnt != 0) ? 1 : 0);
    end
  end
  assign fifo_empty = (fcnt == 0);

  always @(negedge clk) begin
    if (fifo_rd_en === 1'b1) begin
      rd_cnt++;
      if (fifo_empty) rd_viol++;
    end
  end

  // Ideal line waveform of one frame: start, 8 data bits LSB first, stop.
  function automatic logic [FW-1:0] frame_wave(input logic [7:0] b);
    logic [9:0]    bits;
    logic [FW-1:0] w;
    bits = {1'b1, b, 1'b0};
    for (int k = 0; k < FW; k++) w[k] = bits[k / C];
    return w;
  endfunction

  function automatic logic [FW-1:0] done_wave();
    logic [FW-1:0] w;
    w = '0;
    w[FW-1] = 1'b1;
    return w;
  endfunction

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    wr_en = 1'b1; wr_data = b;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Waits (bounded) for a start bit, then records one frame's worth of tx and byte_done.
  task automatic capture(output logic [FW-1:0] samp, output logic [FW-1:0] bd,
                         output int wait_n, output bit got);
    got = 1'b0; wait_n = 0; samp = '1; bd = '0;
    while (!got && wait_n < 300) begin
      @(negedge clk);
      if (tx === 1'b0) got = 1'b1;
      else wait_n++;
    end
    if (got) begin
      samp[0] = tx; bd[0] = byte_done;
      for (int k = 1; k < FW; k++) begin
        @(negedge clk);
        samp[k] = tx; bd[k] = byte_done;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; fifo_rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", fifo_rd_en); end
    checks++; if (byte_done !== 1'b0) begin errors++; $display("FAIL reset_byte_done: got %b expected 0", byte_done); end
    reset = 1'b0; fifo_rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [FW-1:0] samp, bd;
    int w, r0;
    bit got;
    r0 = rd_cnt;
    push(8'hA5);
    en = 1'b1;
    capture(samp, bd, w, got);
    checks++;
    if (!got) begin errors++; $display("FAIL single_frame: timeout waiting for start bit"); end
    else if (samp !== frame_wave(8'hA5)) begin
      errors++; $display("FAIL single_frame: got %h expected %h", samp, frame_wave(8'hA5));
    end
    checks++;
    if (bd !== done_wave()) begin errors++; $display("FAIL single_byte_done: got %h expected %h", bd, done_wave()); end
    repeat (5) @(negedge clk);
    checks++;
    if (rd_cnt - r0 != 1) begin errors++; $display("FAIL single_rd_count: got %0d expected 1", rd_cnt - r0); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: busy got %b expected 0", busy); end
    en = 1'b0;
  endtask

  // Queue a list of bytes with en low, then release en and expect them back-to-back.
  task automatic run_stream(input string name, input logic [7:0] bytes_q[$]);
    logic [FW-1:0] samp, bd;
    int w, r0, bad_gap, bad_frame, bad_bd;
    bit got;
    r0 = rd_cnt; bad_gap = 0; bad_frame = 0; bad_bd = 0;
    foreach (bytes_q[i]) push(bytes_q[i]);
    en = 1'b1;
    foreach (bytes_q[i]) begin
      capture(samp, bd, w, got);
      if (!got || samp !== frame_wave(bytes_q[i])) begin
        bad_frame++;
        $display("FAIL %s_frame%0d: got %h expected %h", name, i, samp, frame_wave(bytes_q[i]));
      end
      if (bd !== done_wave()) bad_bd++;
      if (i > 0 && w != 2) begin
        bad_gap++;
        $display("FAIL %s_gap%0d: got %0d cycles expected 2", name, i, w);
      end
    end
    checks++; if (bad_frame != 0) errors++;
    checks++; if (bad_gap != 0) errors++;
    checks++;
    if (bad_bd != 0) begin errors++; $display("FAIL %s_byte_done: got %0d bad frames expected 0", name, bad_bd); end
    repeat (5) @(negedge clk);
    checks++;
    if (rd_cnt - r0 != bytes_q.size()) begin
      errors++; $display("FAIL %s_rd_count: got %0d expected %0d", name, rd_cnt - r0, bytes_q.size());
    end
    checks++;
    if (busy !== 1'b0 || fifo_empty !== 1'b1) begin
      errors++; $display("FAIL %s_end_idle: busy=%b empty=%b expected busy=0 empty=1", name, busy, fifo_empty);
    end
    en = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    for (int i = 0; i < 16; i++) q.push_back(8'(8'hFF - i));
    run_stream("b2b16", q);
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    for (int i = 0; i < 6; i++) q.push_back(8'($urandom_range(0, 255)));
    run_stream("rand", q);
  endtask

  task automatic test_en_gate();
    logic [FW-1:0] samp, bd;
    int w, r0, lows;
    bit got;
    en = 1'b0; r0 = rd_cnt; lows = 0;
    push(8'h3C);
    push(8'h77);
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    checks++;
    if (rd_cnt - r0 != 0 || lows != 0) begin
      errors++; $display("FAIL en_low_hold: rd=%0d low_cycles=%0d expected 0 and 0", rd_cnt - r0, lows);
    end
    en = 1'b1;
    fork
      capture(samp, bd, w, got);
      begin repeat (12) @(negedge clk); en = 1'b0; end
    join
    checks++;
    if (!got || samp !== frame_wave(8'h3C)) begin
      errors++; $display("FAIL en_drop_frame: got %h expected %h", samp, frame_wave(8'h3C));
    end
    repeat (100) @(negedge clk);
    checks++;
    if (rd_cnt - r0 != 1) begin errors++; $display("FAIL en_drop_rd_count: got %0d expected 1", rd_cnt - r0); end
    checks++;
    if (busy !== 1'b0 || fifo_empty !== 1'b0) begin
      errors++; $display("FAIL en_drop_idle: busy=%b empty=%b expected busy=0 empty=0", busy, fifo_empty);
    end
    en = 1'b1;
    capture(samp, bd, w, got);
    checks++;
    if (!got || samp !== frame_wave(8'h77)) begin
      errors++; $display("FAIL en_resume_frame: got %h expected %h", samp, frame_wave(8'h77));
    end
    repeat (5) @(negedge clk);
    en = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [FW-1:0] samp, bd;
    logic [7:0] b1, b2;
    int w, r0, n;
    bit got;
    b1 = 8'($urandom_range(0, 255));
    b2 = 8'($urandom_range(0, 255));
    r0 = rd_cnt;
    push(b1);
    push(b2);
    en = 1'b1;
    got = 1'b0; n = 0;
    while (!got && n < 300) begin
      @(negedge clk);
      if (tx === 1'b0) got = 1'b1;
      else n++;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL rstmid_start: timeout waiting for start bit"); end
    repeat (4 * C + 1) @(negedge clk);  // inside data bit 3
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_abort: tx=%b busy=%b expected tx=1 busy=0", tx, busy);
    end
    reset = 1'b0;
    capture(samp, bd, w, got);
    checks++;
    if (!got || samp !== frame_wave(b2)) begin
      errors++; $display("FAIL rstmid_next_frame: got %h expected %h", samp, frame_wave(b2));
    end
    repeat (5) @(negedge clk);
    checks++;
    if (rd_cnt - r0 != 2 || fifo_empty !== 1'b1) begin
      errors++; $display("FAIL rstmid_rd_count: got %0d empty=%b expected 2 empty=1", rd_cnt - r0, fifo_empty);
    end
    en = 1'b0;
  endtask

  task automatic test_empty_idle();
    int r0, lows;
    en = 1'b1; r0 = rd_cnt; lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    checks++;
    if (lows != 0) begin errors++; $display("FAIL empty_idle_line: got %0d active cycles expected 0", lows); end
    checks++;
    if (rd_cnt - r0 != 0) begin errors++; $display("FAIL empty_idle_rd: got %0d expected 0", rd_cnt - r0); end
    checks++;
    if (rd_viol != 0) begin errors++; $display("FAIL rd_while_empty: got %0d expected 0", rd_viol); end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_en_gate();
    test_reset_mid();
    test_random();
    test_empty_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
